// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipelined control unit.
// Holds the opcode and function-code encodings, the branch comparator
// encodings, the control FSM state type and the packed ID/EX control
// bundle. It has no ports. Imported by ctrl_decode and pipe_control_unit.
package cpu_ctrl_pkg;

   // ID-stage opcodes
   localparam logic [3:0] OP_HALT  = 4'b0000;
   localparam logic [3:0] OP_ANDI  = 4'b0001;
   localparam logic [3:0] OP_ORI   = 4'b0010;
   localparam logic [3:0] OP_BGT   = 4'b0100;
   localparam logic [3:0] OP_BLT   = 4'b0101;
   localparam logic [3:0] OP_BEQ   = 4'b0110;
   localparam logic [3:0] OP_JMP   = 4'b0111;
   localparam logic [3:0] OP_LBU   = 4'b1010;
   localparam logic [3:0] OP_SB    = 4'b1011;
   localparam logic [3:0] OP_LW    = 4'b1100;
   localparam logic [3:0] OP_SW    = 4'b1101;
   localparam logic [3:0] OP_ATYPE = 4'b1111;

   // A-type function codes, grouped by the register-write pattern they need
   localparam logic [3:0] FUNC_WR_BOTH_0 = 4'b1000;
   localparam logic [3:0] FUNC_WR_BOTH_1 = 4'b0100;
   localparam logic [3:0] FUNC_WR_LOW_0  = 4'b0001;
   localparam logic [3:0] FUNC_WR_LOW_1  = 4'b0010;

   // Branch comparator results from the ID stage
   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_EQ   = 2'b01;
   localparam logic [1:0] BR_GT   = 2'b10;
   localparam logic [1:0] BR_LT   = 2'b11;

   // Control FSM states; encodings are visible on the debug state port
   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_DRAIN = 2'b01,
      ST_HALT  = 2'b10,
      ST_ERROR = 2'b11
   } state_t;

   // ID/EX control bundle
   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic       alu_src_b;
      logic [1:0] reg_write;
      logic       mux_c;
      logic       byte_en;
      logic       mem_write;
      logic       r0_select;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t NOP_BUNDLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder.
// Ports:
//   opcode, function_code  ID-stage instruction fields
//   branch_result          ID comparator result (eq/gt/lt/none)
//   bundle                 decoded ID/EX control bundle
//   branch_taken           conditional branch whose condition holds
//   jump                   unconditional jump opcode
//   halt_op                halt opcode
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [3:0]   opcode,
   input  logic [3:0]   function_code,
   input  logic [1:0]   branch_result,
   output ctrl_bundle_t bundle,
   output logic         branch_taken,
   output logic         jump,
   output logic         halt_op
);

   // Opcode to control bundle. Anything not recognised falls through to
   // the NOP bundle; r0_select simply mirrors a taken conditional branch.
   always_comb begin
      bundle       = NOP_BUNDLE;
      branch_taken = 1'b0;
      jump         = 1'b0;
      halt_op      = 1'b0;
      case (opcode)
         OP_ATYPE: begin
            bundle.alu_op = 2'b01;
            bundle.mux_c  = 1'b1;
            case (function_code)
               FUNC_WR_BOTH_0, FUNC_WR_BOTH_1: bundle.reg_write = 2'b11;
               FUNC_WR_LOW_0,  FUNC_WR_LOW_1:  bundle.reg_write = 2'b01;
               default:                        bundle.reg_write = 2'b00;
            endcase
         end
         OP_ANDI, OP_ORI: begin
            bundle.alu_op    = (opcode == OP_ORI) ? 2'b10 : 2'b00;
            bundle.alu_src_b = 1'b1;
            bundle.mux_c     = 1'b1;
            bundle.reg_write = 2'b10;
         end
         OP_LBU, OP_SB, OP_LW, OP_SW: begin
            bundle.alu_op    = 2'b11;
            bundle.alu_src_a = 1'b1;
            bundle.byte_en   = (opcode == OP_LBU) || (opcode == OP_SB);
            bundle.mem_write = (opcode == OP_SB) || (opcode == OP_SW);
            bundle.reg_write = bundle.mem_write ? 2'b00 : 2'b10;
         end
         OP_BLT:  branch_taken = (branch_result == BR_LT);
         OP_BGT:  branch_taken = (branch_result == BR_GT);
         OP_BEQ:  branch_taken = (branch_result == BR_EQ);
         OP_JMP:  jump         = 1'b1;
         OP_HALT: halt_op      = 1'b1;
         default: ;
      endcase
      bundle.r0_select = branch_taken;
   end

endmodule

// File: rtl/pipe_control_unit.sv
// Registered, hazard-aware pipeline control unit.
// Decodes the ID-stage instruction into a registered ID/EX bundle, drives
// PC redirect, flush and stall combinationally, and sequences halt and
// overflow through a RUN/DRAIN/HALT/ERROR state machine.
// Ports:
//   clk, reset (async, active low)
//   opcode, function_code, branch_result   ID-stage instruction/comparator
//   rs_a, rs_b, ex_rd, ex_is_load          load-use hazard inputs
//   overflow_flag, resume                  EX overflow and operator clear
//   alu_op .. r0_select                    registered ID/EX bundle
//   pc_op, b_jmp, stall, *_flush, halt     combinational pipeline control
//   overflow_error_warning                 registered sticky error flag
//   state                                  FSM state for debug
// Build option: define LOAD_USE_STALL_EN to enable load-use stalls;
// without it the hazard inputs are ignored.
module pipe_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int REG_AW       = 4,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        opcode,
   input  logic [3:0]        function_code,
   input  logic [REG_AW-1:0] rs_a,
   input  logic [REG_AW-1:0] rs_b,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_is_load,
   input  logic [1:0]        branch_result,
   input  logic              overflow_flag,
   input  logic              resume,
   output logic [1:0]        alu_op,
   output logic              alu_src_a,
   output logic              alu_src_b,
   output logic [1:0]        reg_write,
   output logic              mux_c,
   output logic              byte_en,
   output logic              mem_write,
   output logic              r0_select,
   output logic              pc_op,
   output logic              b_jmp,
   output logic              stall,
   output logic              if_flush,
   output logic              id_flush,
   output logic              ex_flush,
   output logic              halt,
   output logic              overflow_error_warning,
   output logic [1:0]        state
);

   // Counter just wide enough to hold DRAIN_CYCLES-1
   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   ctrl_bundle_t dec_bundle;
   logic         dec_taken;
   logic         dec_jump;
   logic         dec_halt;
   logic         hazard;

   state_t       state_q, state_d;
   logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   ctrl_bundle_t bundle_q, bundle_d;
   logic         warn_q, warn_d;

   ctrl_decode u_decode (
      .opcode        (opcode),
      .function_code (function_code),
      .branch_result (branch_result),
      .bundle        (dec_bundle),
      .branch_taken  (dec_taken),
      .jump          (dec_jump),
      .halt_op       (dec_halt)
   );

`ifdef LOAD_USE_STALL_EN
   // A load in EX whose destination is read by the ID instruction must
   // stall one cycle; jmp and halt read no registers so they never wait.
   assign hazard = ex_is_load && (ex_rd != '0) &&
                   ((ex_rd == rs_a) || (ex_rd == rs_b)) &&
                   !dec_jump && !dec_halt;
`else
   // Software schedules around loads, so the hazard inputs are only
   // collected here to keep them visibly intentional.
   logic unused_hazard_inputs;
   assign unused_hazard_inputs = ^{rs_a, rs_b, ex_rd, ex_is_load};
   assign hazard = 1'b0;
`endif

   // Next-state and Mealy output logic. In RUN the causes are taken in
   // priority order: overflow, halt opcode, load-use hazard, redirect.
   // Every non-RUN state registers a NOP bundle.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      bundle_d    = NOP_BUNDLE;
      warn_d      = warn_q;
      pc_op       = 1'b0;
      b_jmp       = 1'b0;
      stall       = 1'b0;
      if_flush    = 1'b0;
      id_flush    = 1'b0;
      ex_flush    = 1'b0;
      halt        = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (overflow_flag) begin
               if_flush = 1'b1;
               id_flush = 1'b1;
               ex_flush = 1'b1;
               halt     = 1'b1;
               warn_d   = 1'b1;
               state_d  = ST_ERROR;
            end else if (dec_halt) begin
               if_flush    = 1'b1;
               stall       = 1'b1;
               drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
               state_d     = ST_DRAIN;
            end else if (hazard) begin
               stall = 1'b1;
            end else begin
               bundle_d = dec_bundle;
               if (dec_taken) begin
                  pc_op    = 1'b1;
                  b_jmp    = 1'b1;
                  if_flush = 1'b1;
               end else if (dec_jump) begin
                  pc_op    = 1'b1;
                  if_flush = 1'b1;
                  id_flush = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            stall    = 1'b1;
            if_flush = 1'b1;
            if (overflow_flag) begin
               warn_d  = 1'b1;
               state_d = ST_ERROR;
            end else if (drain_cnt_q == '0) begin
               state_d = ST_HALT;
            end else begin
               drain_cnt_d = drain_cnt_q - 1'b1;
            end
         end
         ST_HALT: begin
            halt  = 1'b1;
            stall = 1'b1;
         end
         ST_ERROR: begin
            halt     = 1'b1;
            stall    = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
            ex_flush = 1'b1;
            if (resume) begin
               warn_d  = 1'b0;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State, drain counter, sticky warning and the ID/EX register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= '0;
         bundle_q    <= NOP_BUNDLE;
         warn_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         bundle_q    <= bundle_d;
         warn_q      <= warn_d;
      end
   end

   assign alu_op                 = bundle_q.alu_op;
   assign alu_src_a              = bundle_q.alu_src_a;
   assign alu_src_b              = bundle_q.alu_src_b;
   assign reg_write              = bundle_q.reg_write;
   assign mux_c                  = bundle_q.mux_c;
   assign byte_en                = bundle_q.byte_en;
   assign mem_write              = bundle_q.mem_write;
   assign r0_select              = bundle_q.r0_select;
   assign overflow_error_warning = warn_q;
   assign state                  = state_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: a constant vector table for
// the decoder, hand sequences for drain/halt/overflow/hazard/reset, and a
// randomized run compared against a behavioural model.
module tb_pipe_control_unit;

   localparam int DRAIN = 3;
`ifdef LOAD_USE_STALL_EN
   localparam bit HAZ_EN = 1'b1;
`else
   localparam bit HAZ_EN = 1'b0;
`endif

   // Behavioural modes, numbered as the debug state port reports them
   localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_ERROR = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] opcode, function_code;
   logic [3:0] rs_a, rs_b, ex_rd;
   logic       ex_is_load;
   logic [1:0] branch_result;
   logic       overflow_flag, resume;
   logic [1:0] alu_op, reg_write, state;
   logic       alu_src_a, alu_src_b, mux_c, byte_en, mem_write, r0_select;
   logic       pc_op, b_jmp, stall, if_flush, id_flush, ex_flush, halt;
   logic       overflow_error_warning;

   logic [6:0] comb_out;
   logic [9:0] bundle_out;

   int checks   = 0;
   int failures = 0;

   int         m_mode;
   int         m_edges;
   logic       m_warn;
   logic [9:0] m_bundle;

   typedef struct {
      logic [3:0] op;
      logic [3:0] func;
      logic [1:0] br;
      logic [9:0] exp_bundle;
      logic [6:0] exp_comb;
   } vec_t;

   vec_t vecs[19];

   pipe_control_unit #(.REG_AW(4), .DRAIN_CYCLES(DRAIN)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .opcode                 (opcode),
      .function_code          (function_code),
      .rs_a                   (rs_a),
      .rs_b                   (rs_b),
      .ex_rd                  (ex_rd),
      .ex_is_load             (ex_is_load),
      .branch_result          (branch_result),
      .overflow_flag          (overflow_flag),
      .resume                 (resume),
      .alu_op                 (alu_op),
      .alu_src_a              (alu_src_a),
      .alu_src_b              (alu_src_b),
      .reg_write              (reg_write),
      .mux_c                  (mux_c),
      .byte_en                (byte_en),
      .mem_write              (mem_write),
      .r0_select              (r0_select),
      .pc_op                  (pc_op),
      .b_jmp                  (b_jmp),
      .stall                  (stall),
      .if_flush               (if_flush),
      .id_flush               (id_flush),
      .ex_flush               (ex_flush),
      .halt                   (halt),
      .overflow_error_warning (overflow_error_warning),
      .state                  (state)
   );

   always #5 clk = ~clk;

   assign comb_out   = {pc_op, b_jmp, stall, if_flush, id_flush, ex_flush, halt};
   assign bundle_out = {alu_op, alu_src_a, alu_src_b, reg_write, mux_c,
                        byte_en, mem_write, r0_select};

   // Compare one observed value against the bench's expectation
   task automatic check_output(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Drive every DUT input with blocking assignments
   task automatic apply_stimulus(input logic [3:0] op, input logic [3:0] func,
                                 input logic [1:0] br, input logic ld,
                                 input logic [3:0] rd, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic ovf,
                                 input logic res);
      opcode        = op;
      function_code = func;
      branch_result = br;
      ex_is_load    = ld;
      ex_rd         = rd;
      rs_a          = ra;
      rs_b          = rb;
      overflow_flag = ovf;
      resume        = res;
   endtask

   task automatic nop_inputs();
      apply_stimulus(4'b0011, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic edge_and_settle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   // Control bundle as the instruction set describes it,
   // packed {alu_op, src_a, src_b, reg_write, mux_c, byte_en, mem_write, r0}
   function automatic logic [9:0] spec_bundle(input logic [3:0] op,
                                              input logic [3:0] func,
                                              input logic [1:0] br);
      logic [1:0] rw;
      case (op)
         4'b1111: begin
            if (func == 4'b1000 || func == 4'b0100)      rw = 2'b11;
            else if (func == 4'b0001 || func == 4'b0010) rw = 2'b01;
            else                                         rw = 2'b00;
            return {2'b01, 1'b0, 1'b0, rw, 1'b1, 1'b0, 1'b0, 1'b0};
         end
         4'b0001: return 10'b00_0_1_10_1_0_0_0;
         4'b0010: return 10'b10_0_1_10_1_0_0_0;
         4'b1010: return 10'b11_1_0_10_0_1_0_0;
         4'b1011: return 10'b11_1_0_00_0_1_1_0;
         4'b1100: return 10'b11_1_0_10_0_0_0_0;
         4'b1101: return 10'b11_1_0_00_0_0_1_0;
         4'b0101: return (br == 2'b11) ? 10'd1 : 10'd0;
         4'b0100: return (br == 2'b10) ? 10'd1 : 10'd0;
         4'b0110: return (br == 2'b01) ? 10'd1 : 10'd0;
         default: return 10'd0;
      endcase
   endfunction

   initial begin
      logic [6:0] exp_comb;
      logic [3:0] r_op;

      vecs[0]  = '{4'b1111, 4'b1000, 2'b00, 10'b0100111000, 7'b0000000};
      vecs[1]  = '{4'b1111, 4'b0100, 2'b00, 10'b0100111000, 7'b0000000};
      vecs[2]  = '{4'b1111, 4'b0001, 2'b00, 10'b0100011000, 7'b0000000};
      vecs[3]  = '{4'b1111, 4'b0010, 2'b00, 10'b0100011000, 7'b0000000};
      vecs[4]  = '{4'b1111, 4'b0111, 2'b00, 10'b0100001000, 7'b0000000};
      vecs[5]  = '{4'b0001, 4'b0000, 2'b00, 10'b0001101000, 7'b0000000};
      vecs[6]  = '{4'b0010, 4'b0000, 2'b00, 10'b1001101000, 7'b0000000};
      vecs[7]  = '{4'b1010, 4'b0000, 2'b00, 10'b1110100100, 7'b0000000};
      vecs[8]  = '{4'b1011, 4'b0000, 2'b00, 10'b1110000110, 7'b0000000};
      vecs[9]  = '{4'b1100, 4'b0000, 2'b00, 10'b1110100000, 7'b0000000};
      vecs[10] = '{4'b1101, 4'b0000, 2'b00, 10'b1110000010, 7'b0000000};
      vecs[11] = '{4'b0101, 4'b0000, 2'b11, 10'b0000000001, 7'b1101000};
      vecs[12] = '{4'b0101, 4'b0000, 2'b10, 10'b0000000000, 7'b0000000};
      vecs[13] = '{4'b0100, 4'b0000, 2'b10, 10'b0000000001, 7'b1101000};
      vecs[14] = '{4'b0110, 4'b0000, 2'b01, 10'b0000000001, 7'b1101000};
      vecs[15] = '{4'b0110, 4'b0000, 2'b00, 10'b0000000000, 7'b0000000};
      vecs[16] = '{4'b0111, 4'b0000, 2'b00, 10'b0000000000, 7'b1001100};
      vecs[17] = '{4'b0011, 4'b0000, 2'b11, 10'b0000000000, 7'b0000000};
      vecs[18] = '{4'b1110, 4'b0000, 2'b01, 10'b0000000000, 7'b0000000};

      // Reset state
      reset = 1'b0;
      nop_inputs();
      #12;
      check_output("reset_bundle", 16'(bundle_out), 16'h0);
      check_output("reset_comb", 16'(comb_out), 16'h0);
      check_output("reset_warn", 16'(overflow_error_warning), 16'h0);
      check_output("reset_state", 16'(state), 16'h0);
      @(negedge clk);
      reset = 1'b1;
      edge_and_settle();

      // Decoder table, one instruction per cycle from RUN
      for (int i = 0; i < 19; i++) begin
         apply_stimulus(vecs[i].op, vecs[i].func, vecs[i].br, 1'b0, 4'h0,
                        4'h0, 4'h0, 1'b0, 1'b0);
         @(negedge clk);
         check_output($sformatf("vec%0d_comb", i), 16'(comb_out), 16'(vecs[i].exp_comb));
         edge_and_settle();
         check_output($sformatf("vec%0d_bundle", i), 16'(bundle_out), 16'(vecs[i].exp_bundle));
      end

      // Load-use hazard ahead of a taken beq, then the retry
      apply_stimulus(4'b0110, 4'h0, 2'b01, 1'b1, 4'd3, 4'd0, 4'd3, 1'b0, 1'b0);
      @(negedge clk);
      check_output("hazard_comb", 16'(comb_out), HAZ_EN ? 16'h10 : 16'h68);
      edge_and_settle();
      check_output("hazard_bundle", 16'(bundle_out), HAZ_EN ? 16'h0 : 16'h1);
      apply_stimulus(4'b0110, 4'h0, 2'b01, 1'b0, 4'd3, 4'd0, 4'd3, 1'b0, 1'b0);
      @(negedge clk);
      check_output("retry_comb", 16'(comb_out), 16'h68);
      edge_and_settle();
      check_output("retry_bundle", 16'(bundle_out), 16'h1);

      // Halt opcode drains for DRAIN cycles, then halts until reset
      apply_stimulus(4'b0000, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      check_output("halt_op_comb", 16'(comb_out), 16'h18);
      edge_and_settle();
      check_output("drain_state0", 16'(state), 16'd1);
      apply_stimulus(4'b0010, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      for (int k = 1; k <= DRAIN; k++) begin
         @(negedge clk);
         check_output($sformatf("drain_comb%0d", k), 16'(comb_out), 16'h18);
         edge_and_settle();
         check_output($sformatf("drain_state%0d", k), 16'(state),
                      (k == DRAIN) ? 16'd2 : 16'd1);
         check_output($sformatf("drain_bundle%0d", k), 16'(bundle_out), 16'h0);
      end
      @(negedge clk);
      check_output("halted_comb", 16'(comb_out), 16'h11);
      edge_and_settle();
      check_output("halted_resume_ignored", 16'(state), 16'd2);
      apply_stimulus(4'b0010, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      edge_and_settle();
      check_output("halted_ovf_ignored", 16'(overflow_error_warning), 16'h0);
      do_reset();

      // Overflow in RUN, then resume
      apply_stimulus(4'b0010, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      @(negedge clk);
      check_output("ovf_comb", 16'(comb_out), 16'h0F);
      edge_and_settle();
      check_output("ovf_warn", 16'(overflow_error_warning), 16'h1);
      check_output("ovf_state", 16'(state), 16'd3);
      check_output("ovf_bundle", 16'(bundle_out), 16'h0);
      apply_stimulus(4'b0010, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      check_output("error_comb", 16'(comb_out), 16'h1F);
      edge_and_settle();
      check_output("resume_warn", 16'(overflow_error_warning), 16'h0);
      check_output("resume_state", 16'(state), 16'd0);
      apply_stimulus(4'b0010, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      edge_and_settle();
      check_output("resume_first_decode", 16'(bundle_out), 16'h268);

      // Overflow while the drain counter is at 1, then async reset in ERROR
      apply_stimulus(4'b0000, 4'h0, 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      edge_and_settle();
      nop_inputs();
      edge_and_settle();
      overflow_flag = 1'b1;
      edge_and_settle();
      check_output("drain_ovf_state", 16'(state), 16'd3);
      check_output("drain_ovf_warn", 16'(overflow_error_warning), 16'h1);
      nop_inputs();
      #2;
      reset = 1'b0;
      #1;
      check_output("async_state", 16'(state), 16'd0);
      check_output("async_warn", 16'(overflow_error_warning), 16'h0);
      check_output("async_comb", 16'(comb_out), 16'h0);
      check_output("async_bundle", 16'(bundle_out), 16'h0);
      reset = 1'b1;
      edge_and_settle();

      // Randomized run against the behavioural model
      m_mode = M_RUN; m_edges = 0; m_warn = 1'b0; m_bundle = '0;
      for (int i = 0; i < 400; i++) begin
         logic       taken, is_jmp, is_halt, haz;
         int         n_mode;
         logic       n_warn;
         logic [9:0] n_bundle;
         if (i % 50 == 0) begin
            do_reset();
            m_mode = M_RUN; m_edges = 0; m_warn = 1'b0; m_bundle = '0;
         end
         r_op = 4'($urandom_range(0, 15));
         if (r_op == 4'b0000 && $urandom_range(0, 3) != 0) r_op = 4'b1111;
         apply_stimulus(r_op, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                        4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                        ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));

         taken   = (r_op == 4'b0101 && branch_result == 2'b11) ||
                   (r_op == 4'b0100 && branch_result == 2'b10) ||
                   (r_op == 4'b0110 && branch_result == 2'b01);
         is_jmp  = (r_op == 4'b0111);
         is_halt = (r_op == 4'b0000);
         haz     = HAZ_EN && ex_is_load && ex_rd != 0 &&
                   (ex_rd == rs_a || ex_rd == rs_b) && !is_jmp && !is_halt;

         exp_comb = '0;
         n_mode   = m_mode;
         n_warn   = m_warn;
         n_bundle = '0;
         if (m_mode == M_RUN) begin
            if (overflow_flag) begin
               exp_comb = 7'b0001111; n_mode = M_ERROR; n_warn = 1'b1;
            end else if (is_halt) begin
               exp_comb = 7'b0011000; n_mode = M_DRAIN; m_edges = 1;
            end else if (haz) begin
               exp_comb = 7'b0010000;
            end else begin
               n_bundle = spec_bundle(r_op, function_code, branch_result);
               if (taken)       exp_comb = 7'b1101000;
               else if (is_jmp) exp_comb = 7'b1001100;
            end
         end else if (m_mode == M_DRAIN) begin
            exp_comb = 7'b0011000;
            if (overflow_flag) begin
               n_mode = M_ERROR; n_warn = 1'b1;
            end else begin
               m_edges++;
               if (m_edges == DRAIN + 1) n_mode = M_HALT;
            end
         end else if (m_mode == M_HALT) begin
            exp_comb = 7'b0010001;
         end else begin
            exp_comb = 7'b0011111;
            if (resume) begin
               n_mode = M_RUN; n_warn = 1'b0;
            end
         end

         @(negedge clk);
         check_output($sformatf("rnd%0d_comb", i), 16'(comb_out), 16'(exp_comb));
         edge_and_settle();
         m_mode = n_mode; m_warn = n_warn; m_bundle = n_bundle;
         check_output($sformatf("rnd%0d_bundle", i), 16'(bundle_out), 16'(m_bundle));
         check_output($sformatf("rnd%0d_warn", i), 16'(overflow_error_warning), 16'(m_warn));
         check_output($sformatf("rnd%0d_state", i), 16'(state), 16'(m_mode));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Registered, hazard-aware successor to the single-cycle control decoder. It decodes the ID-stage instruction and drives the ID/EX control bundle through a register. It also generates the PC redirect and flush/stall signals, and sequences halt and overflow through a small state machine with a parametrised pipeline drain.

## Interface
Parameters:
- REG_AW, 4: register-address width for hazard comparison.
- DRAIN_CYCLES, 3: cycles allowed for older instructions to retire after a halt opcode (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- opcode  in  4  ID-stage opcode
- function_code  in  4  ID-stage function field (A-type)
- rs_a, rs_b  in  REG_AW  ID-stage source registers
- ex_rd  in  REG_AW  EX-stage destination register
- ex_is_load  in  1  EX-stage instruction is lbu/lw
- branch_result  in  2  ID comparator: 01 eq, 10 gt, 11 lt, 00 none
- overflow_flag  in  1  EX-stage ALU overflow
- resume  in  1  operator clear of the overflow error
- alu_op  out  2,  alu_src_a, alu_src_b  out  1,  reg_write  out  2,  mux_c, byte_en, mem_write, r0_select  out  1: registered ID/EX bundle
- pc_op, b_jmp, stall, if_flush, id_flush, ex_flush, halt  out  1: combinational pipeline control
- overflow_error_warning  out  1  registered, sticky
- state  out  2  FSM state (debug)

## Operation
- Decode (bundle fields unlisted are 0):
  - 1111 A-type: alu_op=01, mux_c=1. reg_write=11 for func 1000/0100, 01 for 0001/0010, 00 otherwise.
  - 0001 andi: alu_op=00, alu_src_b=1, mux_c=1, reg_write=10.
  - 0010 ori: same as andi with alu_op=10.
  - 1010 lbu: alu_op=11, alu_src_a=1, byte_en=1, reg_write=10.
  - 1011 sb: as lbu with mem_write=1, reg_write=00.
  - 1100 lw / 1101 sw: as lbu/sb with byte_en=0.
  - Branches 0101 blt (taken on 11), 0100 bgt (10), 0110 beq (01): r0_select=1 when taken. mem_write is always 0.
  - 0111 jmp: always taken.
  - 0000 halt. Any other opcode: NOP bundle.
- FSM states: RUN=00, DRAIN=01, HALT=10, ERROR=11.
- RUN actions, evaluated in this priority order:
  1. overflow_flag: if_flush=id_flush=ex_flush=halt=1; next state ERROR; warning set.
  2. halt opcode: if_flush=1, stall=1; load drain counter with DRAIN_CYCLES−1; next state DRAIN.
  3. Load-use hazard: occurs when ex_is_load and ex_rd≠0 and ex_rd∈{rs_a, rs_b}, for opcodes other than jmp/halt. Response: stall=1, NOP bundle registered, branch not evaluated this cycle.
  4. Taken branch: pc_op=1, b_jmp=1, if_flush=1. jmp: pc_op=1, b_jmp=0, if_flush=1, id_flush=1.
- DRAIN: NOP bundle, stall=1, if_flush=1, halt=0. Counter decrements each cycle; at 0, next state HALT. Overflow preempts the drain and goes to ERROR.
- HALT: halt=1, stall=1, NOP bundle. Exited only by reset.
- ERROR: halt=1, stall=1, all flushes=1, NOP bundle. resume=1 clears the warning and returns to RUN on the next edge; the first instruction decodes from RUN.
- Overflow inside HALT is ignored.

## Timing
- Reset values: bundle all 0, overflow_error_warning=0, state=RUN, drain counter 0.
- Combinational outputs follow the reset-state values: all 0 except as decoded from current inputs.
- Bundle latency: 1 cycle (decode in cycle N appears at the ID/EX outputs in N+1).
- Redirect/flush/stall: same cycle as the causing input (Mealy).
- Halt opcode to halt=1: exactly DRAIN_CYCLES+1 edges.
- overflow_error_warning rises the edge after overflow_flag.
- Reset asserted mid-DRAIN or in ERROR: immediate return to reset values, no clock needed.

## Configuration
- LOAD_USE_STALL_EN defined: hazard detection as above.
- Not defined: stall is driven only by DRAIN/HALT/ERROR; rs_a, rs_b, ex_rd, ex_is_load are ignored (software schedules loads).

## Structure
- cpu_ctrl_pkg holds the opcode and function-code localparams, the branch_result encodings, the FSM state enum, and a packed ctrl_bundle_t struct.
- One sub-module, ctrl_decode: purely combinational opcode/function → ctrl_bundle_t plus a branch-taken/jump indication.
- The FSM, hazard logic, drain counter and ID/EX register live in the top.

## Test plan
- Reset, then opcode=0010 → next edge: alu_op=10, alu_src_b=1, mux_c=1, reg_write=10; all flushes 0.
- ex_is_load=1, ex_rd=3, rs_b=3, opcode=0110, branch_result=01 → stall=1, pc_op=0, NOP registered. Next cycle ex_is_load=0 → pc_op=1, b_jmp=1, if_flush=1, r0_select=1 registered.
- opcode=0000 with DRAIN_CYCLES=3 → state 01 for 3 cycles, then 10 with halt=1. resume has no effect; only reset exits.
- overflow_flag=1 in RUN → same cycle if/id/ex_flush=1, halt=1; next edge warning=1, state=11. resume=1 → warning=0, state=00.
- overflow_flag during DRAIN (count 1) → ERROR, not HALT. Reset mid-ERROR → all outputs 0 asynchronously.
- With LOAD_USE_STALL_EN undefined, repeat the hazard case → stall=0, branch taken immediately.
